// File: rtl/mem_arbiter_if.sv
// Request/response and memory-side bus of the unified-memory arbiter.
// master = arbiter view; slave = requesters plus memory macro view.
interface mem_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_gnt;
  logic        cpu_stall;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;

  logic        dma_req;
  logic        dma_we;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic        dma_gnt;
  logic        dma_rvalid;
  logic [31:0] dma_rdata;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output mem_addr, mem_wdata, mem_read, mem_write,
    input  mem_rdata
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  mem_addr, mem_wdata, mem_read, mem_write,
    output mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between the CPU core (C) and the DMA/loader (D).
// C has priority until D starves for MAX_WAIT cycles; D bursts are capped at BURST_LEN.
module mem_arbiter #(
  parameter int MAX_WAIT  = 8,
  parameter int BURST_LEN = 4
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.master bus
);

  typedef enum logic {IDLE, DMA_BURST} state_e;

  localparam logic [7:0] MAX_WAIT_C  = 8'(MAX_WAIT);
  localparam logic [7:0] BURST_LEN_C = 8'(BURST_LEN);

  state_e      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic [7:0]  burst_q, burst_d;
  logic        rvalid_q, rvalid_d;
  logic        rd_owner_q, rd_owner_d;   // 1 = read in flight belongs to D
  logic [31:0] rdata_q, rdata_d;
  logic        cgnt, dgnt;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wait_q     <= '0;
      burst_q    <= '0;
      rvalid_q   <= 1'b0;
      rd_owner_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      burst_q    <= burst_d;
      rvalid_q   <= rvalid_d;
      rd_owner_q <= rd_owner_d;
      rdata_q    <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    burst_d = burst_q;
    cgnt    = 1'b0;
    dgnt    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.dma_req && (!bus.cpu_req || wait_q >= MAX_WAIT_C)) begin
          dgnt    = 1'b1;
          state_d = DMA_BURST;
          burst_d = 8'd1;
        end else if (bus.cpu_req) begin
          cgnt = 1'b1;
          if (bus.dma_req) wait_d = sat_inc(wait_q);
        end
      end
      DMA_BURST: begin
        if (bus.dma_req && (!bus.cpu_req || burst_q < BURST_LEN_C)) begin
          dgnt    = 1'b1;
          burst_d = sat_inc(burst_q);
        end else begin
          cgnt    = bus.cpu_req;
          state_d = IDLE;
          burst_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    // Starvation count only spans an unbroken run of denied D requests.
    if (dgnt || !bus.dma_req) wait_d = '0;

    rvalid_d   = (cgnt && !bus.cpu_we) || (dgnt && !bus.dma_we);
    rd_owner_d = dgnt;
    rdata_d    = rvalid_d ? bus.mem_rdata : rdata_q;
  end

  // Grants are qualified by reset so nothing reaches the macro while it is held.
  always_comb begin
    bus.cpu_gnt   = cgnt & ~reset;
    bus.dma_gnt   = dgnt & ~reset;
    bus.cpu_stall = bus.cpu_req & ~bus.cpu_gnt & ~reset;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    if (bus.cpu_gnt) begin
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
      bus.mem_read  = ~bus.cpu_we;
      bus.mem_write = bus.cpu_we;
    end else if (bus.dma_gnt) begin
      bus.mem_addr  = bus.dma_addr;
      bus.mem_wdata = bus.dma_wdata;
      bus.mem_read  = ~bus.dma_we;
      bus.mem_write = bus.dma_we;
    end
    bus.cpu_rvalid = rvalid_q & ~rd_owner_q;
    bus.dma_rvalid = rvalid_q & rd_owner_q;
    bus.cpu_rdata  = rdata_q;
    bus.dma_rdata  = rdata_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a word-addressed memory model.
module tb_mem_arbiter;
  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [31:0] mem [0:255];
  logic [31:0] wd;

  mem_arbiter_if bus();

  mem_arbiter #(.MAX_WAIT(8), .BURST_LEN(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_rdata = mem[bus.mem_addr[9:2]];
  always @(posedge clk) if (bus.mem_write) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0] = 32'h1111_1111;
    mem[1] = 32'h2222_2222;
    mem[2] = 32'h3333_3333;
    mem[4] = 32'hDEAD_BEEF;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = '0; bus.dma_wdata = '0;
    reset = 1'b1;

    // Reset state, with C requesting: nothing may be granted or stalled
    bus.cpu_req = 1'b1;
    #2;
    chk("rst_cpu_gnt",   bus.cpu_gnt,    1'b0);
    chk("rst_cpu_stall", bus.cpu_stall,  1'b0);
    chk("rst_mem_read",  bus.mem_read,   1'b0);
    chk("rst_cpu_rvld",  bus.cpu_rvalid, 1'b0);
    chk("rst_rdata",     bus.cpu_rdata,  32'h0);
    bus.cpu_req = 1'b0;
    @(posedge clk); @(posedge clk);
    #1 reset = 1'b0;

    // C-only read of 0x10
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h10;
    #1;
    chk("c_rd_gnt",   bus.cpu_gnt,   1'b1);
    chk("c_rd_mread", bus.mem_read,  1'b1);
    chk("c_rd_maddr", bus.mem_addr,  32'h10);
    chk("c_rd_stall", bus.cpu_stall, 1'b0);
    tick;
    bus.cpu_req = 1'b0;
    #1;
    chk("c_rd_rvld",  bus.cpu_rvalid, 1'b1);
    chk("c_rd_rdata", bus.cpu_rdata,  32'hDEAD_BEEF);
    chk("c_rd_drvld", bus.dma_rvalid, 1'b0);
    tick;
    chk("c_rd_rvld_off", bus.cpu_rvalid, 1'b0);

    // Both requesting: 8 C grants, then a 4-deep D write burst, then C
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h20;
    bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 32'h200; bus.dma_wdata = 32'h55;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("both_c_gnt", bus.cpu_gnt, 1'b1);
      chk("both_d_gnt", bus.dma_gnt, 1'b0);
      tick;
    end
    for (int j = 0; j < 4; j++) begin
      #1;
      chk("burst_d_gnt", bus.dma_gnt,   1'b1);
      chk("burst_stall", bus.cpu_stall, 1'b1);
      chk("burst_mwr",   bus.mem_write, 1'b1);
      chk("burst_maddr", bus.mem_addr,  32'h200);
      tick;
    end
    #1;
    chk("burst_end_c_gnt", bus.cpu_gnt,    1'b1);
    chk("burst_end_d_gnt", bus.dma_gnt,    1'b0);
    chk("burst_no_drvld",  bus.dma_rvalid, 1'b0);
    tick;

    // D-only write burst of 10 words
    bus.cpu_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wd = 32'hA000_0000 + 32'(i);
      bus.dma_req = 1'b1; bus.dma_we = 1'b1;
      bus.dma_addr = 32'h100 + 32'(4 * i); bus.dma_wdata = wd;
      #1;
      chk("dwr_gnt",   bus.dma_gnt,   1'b1);
      chk("dwr_mwr",   bus.mem_write, 1'b1);
      chk("dwr_maddr", bus.mem_addr,  32'h100 + 32'(4 * i));
      chk("dwr_wdata", bus.mem_wdata, wd);
      chk("dwr_rvld",  bus.dma_rvalid, 1'b0);
      tick;
    end
    bus.dma_req = 1'b0;
    chk("dwr_mem_first", mem[64], 32'hA000_0000);
    chk("dwr_mem_last",  mem[73], 32'hA000_0009);
    chk("dwr_rvld_end",  bus.dma_rvalid, 1'b0);

    // Alternating reads C 0x0 -> D 0x4 -> C 0x8
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h0;
    #1;
    chk("alt1_c_gnt", bus.cpu_gnt, 1'b1);
    tick;
    bus.cpu_req = 1'b0;
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 32'h4;
    #1;
    chk("alt2_d_gnt",  bus.dma_gnt,    1'b1);
    chk("alt2_c_rvld", bus.cpu_rvalid, 1'b1);
    chk("alt2_rdata",  bus.cpu_rdata,  32'h1111_1111);
    chk("alt2_d_rvld", bus.dma_rvalid, 1'b0);
    tick;
    bus.dma_req = 1'b0;
    bus.cpu_req = 1'b1; bus.cpu_addr = 32'h8;
    #1;
    chk("alt3_c_gnt",  bus.cpu_gnt,    1'b1);
    chk("alt3_d_rvld", bus.dma_rvalid, 1'b1);
    chk("alt3_rdata",  bus.dma_rdata,  32'h2222_2222);
    chk("alt3_c_rvld", bus.cpu_rvalid, 1'b0);
    tick;
    bus.cpu_req = 1'b0;
    #1;
    chk("alt4_c_rvld", bus.cpu_rvalid, 1'b1);
    chk("alt4_rdata",  bus.cpu_rdata,  32'h3333_3333);
    chk("alt4_excl",   bus.cpu_rvalid & bus.dma_rvalid, 1'b0);
    tick;

    // Reset mid-burst with a D read in flight
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 32'h4;
    #1;
    chk("mid_d_gnt1", bus.dma_gnt, 1'b1);
    tick;
    bus.dma_addr = 32'h8;
    #1;
    chk("mid_d_gnt2", bus.dma_gnt,    1'b1);
    chk("mid_d_rvld", bus.dma_rvalid, 1'b1);
    #1 reset = 1'b1;
    bus.cpu_req = 1'b1; bus.cpu_addr = 32'h0;
    #1;
    chk("arst_d_rvld", bus.dma_rvalid, 1'b0);
    chk("arst_d_gnt",  bus.dma_gnt,    1'b0);
    chk("arst_c_gnt",  bus.cpu_gnt,    1'b0);
    chk("arst_mread",  bus.mem_read,   1'b0);
    chk("arst_stall",  bus.cpu_stall,  1'b0);
    chk("arst_rdata",  bus.dma_rdata,  32'h0);
    tick;
    #1 reset = 1'b0;
    #1;
    chk("rel_c_first", bus.cpu_gnt, 1'b1);
    chk("rel_d_held",  bus.dma_gnt, 1'b0);
    tick;
    // Build up some starvation, then reset must restart it from zero
    for (int i = 0; i < 4; i++) tick;
    #1 reset = 1'b1;
    #1 reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("wrst_c_gnt", bus.cpu_gnt, 1'b1);
      tick;
    end
    #1;
    chk("wrst_d_gnt", bus.dma_gnt, 1'b1);
    chk("wrst_c_off", bus.cpu_gnt, 1'b0);
    tick;
    bus.cpu_req = 1'b0; bus.dma_req = 1'b0;
    tick;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
